fetch_queue: RTL

- Decoupling instruction queue between instruction fetch and the IF->OF pipe register of the in-order single-issue RV32 core.
- Absorbs fetch bubbles and dependency-control stalls so fetch keeps streaming while OF is held.
- Discards all queued instructions on a branch redirect from execute.
- Holds {pc, instr} pairs in order. First-word-fall-through on the read side.

---
 rtl/fetch_queue.sv | 93 +++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Decoupling queue of {pc, instr} pairs between instruction fetch and the IF->OF register.
// First-word-fall-through read side, whole-queue discard on branch redirect.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       flush,
    input  logic                       push_valid,
    input  logic [XLEN-1:0]            push_pc,
    input  logic [XLEN-1:0]            push_instr,
    output logic                       push_ready,
    output logic                       pop_valid,
    output logic [XLEN-1:0]            pop_pc,
    output logic [XLEN-1:0]            pop_instr,
    input  logic                       pop_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic [15:0]                flush_drops
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [XLEN-1:0]  r_pc_mem    [DEPTH];
    logic [XLEN-1:0]  r_instr_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [15:0]      r_flush_drops;

    logic w_push_fire;
    logic w_pop_fire;
    logic w_empty;
    logic w_full;

    function automatic logic [15:0] sat_add_drops(input logic [15:0] acc,
                                                  input logic [CNT_W-1:0] add);
        logic [16:0] sum;
        sum = {1'b0, acc} + 17'(add);
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    // Handshakes come from registered occupancy only, so pop_ready never reaches push_ready.
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == FULL_CNT);
    assign push_ready  = !w_full;
    assign pop_valid   = !w_empty;
    assign w_push_fire = push_valid && push_ready;
    assign w_pop_fire  = pop_valid && pop_ready;

    assign pop_pc      = w_empty ? '0 : r_pc_mem[r_rd_ptr];
    assign pop_instr   = w_empty ? '0 : r_instr_mem[r_rd_ptr];
    assign count       = r_count;
    assign flush_drops = r_flush_drops;

    // Storage is never cleared; only pointers and occupancy decide what is visible.
    always_ff @(posedge clk) begin
        if (resetn && !flush && w_push_fire) begin
            r_pc_mem[r_wr_ptr]    <= push_pc;
            r_instr_mem[r_wr_ptr] <= push_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_flush_drops <= '0;
        end else if (flush) begin
            // Same-cycle push belongs to the wrong path and is dropped with the rest.
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_flush_drops <= sat_add_drops(r_flush_drops, r_count);
        end else begin
            if (w_push_fire) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_fire) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_fire, w_pop_fire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
